// File: rtl/result_port_arbiter.sv
// Result-port arbiter: fixed-latency pipeline vs. iterative div/sqrt unit.
// Pipeline wins conflicts; a starved divider gets a one-cycle forced grant.
package fraction_lsbs;
  typedef enum logic [2:0] {
    ZEROS   = 3'd0,
    A       = 3'd1,
    B       = 3'd2,
    RESULT  = 3'd3,
    IRESULT = 3'd4
  } fraction_lsbs_select;
endpackage

module result_port_arbiter
  import fraction_lsbs::*;
#(
  parameter int TAG_WIDTH    = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pipe_valid,
  input  fraction_lsbs_select  pipe_sel,
  input  logic [TAG_WIDTH-1:0] pipe_tag,
  input  logic                 div_valid,
  input  fraction_lsbs_select  div_sel,
  input  logic [TAG_WIDTH-1:0] div_tag,
  output logic                 div_ready,
  output logic                 pipe_stall,
  output logic                 res_valid,
  output fraction_lsbs_select  res_sel,
  output logic [TAG_WIDTH-1:0] res_tag,
  output logic                 sel_error
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    FORCE
  } state_t;

  localparam logic [3:0] LIM = 4'(STARVE_LIMIT - 1);

  state_t               state;
  state_t               state_n;
  logic [3:0]           cnt;
  logic [3:0]           cnt_n;
  logic                 pipe_acc;
  logic                 blocked;
  logic                 win_vld;
  fraction_lsbs_select  win_sel;
  logic [TAG_WIDTH-1:0] win_tag;
  logic                 sel_ok;

  always_comb begin
    div_ready = !reset && div_valid &&
                (state == FORCE || !pipe_valid);
    pipe_acc  = !reset && pipe_valid && !pipe_stall;
    blocked   = div_valid && !div_ready;
  end

  // counter saturates so it can never wrap past the limit
  always_comb begin
    state_n = state;
    cnt_n   = '0;
    if (blocked)
      cnt_n = (cnt == LIM) ? cnt : cnt + 4'd1;
    unique case (state)
      IDLE:  if (blocked) state_n = WAIT;
      WAIT: begin
        if (!blocked)        state_n = IDLE;
        else if (cnt == LIM) state_n = FORCE;
      end
      FORCE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    win_vld = 1'b0;
    win_sel = ZEROS;
    win_tag = '0;
    unique case (1'b1)
      pipe_acc: begin
        win_vld = 1'b1;
        win_sel = pipe_sel;
        win_tag = pipe_tag;
      end
      div_ready: begin
        win_vld = 1'b1;
        win_sel = div_sel;
        win_tag = div_tag;
      end
      default: ;
    endcase
    sel_ok = win_sel inside {ZEROS, A, B, RESULT, IRESULT};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      pipe_stall <= 1'b0;
      res_valid  <= 1'b0;
      res_sel    <= ZEROS;
      res_tag    <= '0;
      sel_error  <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      pipe_stall <= (state_n == FORCE);
      res_valid  <= win_vld;
      res_sel    <= sel_ok ? win_sel : ZEROS;
      res_tag    <= win_tag;
      if (win_vld && !sel_ok)
        sel_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_result_port_arbiter.sv
// Scoreboard bench for result_port_arbiter: directed vectors,
// expected results queued at drive time and popped by a monitor.
module tb_result_port_arbiter;
  import fraction_lsbs::*;

  localparam int TW  = 4;
  localparam int LIM = 8;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                pipe_valid = 1'b0;
  fraction_lsbs_select pipe_sel = ZEROS;
  logic [TW-1:0]       pipe_tag = '0;
  logic                div_valid = 1'b0;
  fraction_lsbs_select div_sel = ZEROS;
  logic [TW-1:0]       div_tag = '0;
  logic                div_ready;
  logic                pipe_stall;
  logic                res_valid;
  fraction_lsbs_select res_sel;
  logic [TW-1:0]       res_tag;
  logic                sel_error;

  result_port_arbiter #(
    .TAG_WIDTH(TW),
    .STARVE_LIMIT(LIM)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pipe_valid(pipe_valid),
    .pipe_sel(pipe_sel),
    .pipe_tag(pipe_tag),
    .div_valid(div_valid),
    .div_sel(div_sel),
    .div_tag(div_tag),
    .div_ready(div_ready),
    .pipe_stall(pipe_stall),
    .res_valid(res_valid),
    .res_sel(res_sel),
    .res_tag(res_tag),
    .sel_error(sel_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    string               name;
    logic                rv;
    fraction_lsbs_select rs;
    logic [TW-1:0]       rt;
    logic                st;
    logic                er;
  } exp_t;

  exp_t sbq[$];
  exp_t m;
  int   n_vec  = 0;
  int   n_fail = 0;
  logic exp_err = 1'b0;
  fraction_lsbs_select bad_sel;

  always @(posedge clk) begin
    #2;
    if (sbq.size() > 0) begin
      m = sbq.pop_front();
      n_vec++;
      if (res_valid !== m.rv || res_sel !== m.rs ||
          res_tag !== m.rt || pipe_stall !== m.st ||
          sel_error !== m.er) begin
        n_fail++;
        $display("FAIL %s: got v=%b s=%0d t=%0d st=%b e=%b want v=%b s=%0d t=%0d st=%b e=%b",
          m.name, res_valid, res_sel, res_tag, pipe_stall,
          sel_error, m.rv, m.rs, m.rt, m.st, m.er);
      end
    end
  end

  task automatic step(
    input string               nm,
    input logic                rst,
    input logic                pv,
    input fraction_lsbs_select ps,
    input logic [TW-1:0]       pt,
    input logic                dv,
    input fraction_lsbs_select ds,
    input logic [TW-1:0]       dt,
    input logic                xdr,
    input logic                xrv,
    input fraction_lsbs_select xrs,
    input logic [TW-1:0]       xrt,
    input logic                xst
  );
    exp_t e;
    @(negedge clk);
    reset      = rst;
    pipe_valid = pv;
    pipe_sel   = ps;
    pipe_tag   = pt;
    div_valid  = dv;
    div_sel    = ds;
    div_tag    = dt;
    #1;
    n_vec++;
    if (div_ready !== xdr) begin
      n_fail++;
      $display("FAIL %s div_ready: got %b want %b",
        nm, div_ready, xdr);
    end
    e.name = nm;
    e.rv   = xrv;
    e.rs   = xrs;
    e.rt   = xrt;
    e.st   = xst;
    e.er   = exp_err;
    sbq.push_back(e);
  endtask

  task automatic idle(input string nm);
    step(nm, 0, 0, ZEROS, 0, 0, ZEROS, 0,
         0, 0, ZEROS, 0, 0);
  endtask

  // LIM blocked cycles; stall shows after the last, then FORCE grant
  task automatic starve(
    input string               nm,
    input fraction_lsbs_select ds,
    input logic [TW-1:0]       dt,
    input bit                  grant
  );
    for (int i = 1; i <= LIM; i++)
      step(nm, 0, 1, RESULT, TW'(i), 1, ds, dt,
           0, 1, RESULT, TW'(i), i == LIM);
    if (grant)
      step({nm, "_force"}, 0, 1, RESULT, 4'd15, 1, ds, dt,
           1, 1, ds, dt, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bad_sel = fraction_lsbs_select'(3'd6);

    step("reset0", 1, 0, ZEROS, 0, 0, ZEROS, 0,
         0, 0, ZEROS, 0, 0);
    step("reset_dv", 1, 1, A, 4'd2, 1, B, 4'd9,
         0, 0, ZEROS, 0, 0);

    step("pipe_res", 0, 1, RESULT, 4'd3, 0, ZEROS, 0,
         0, 1, RESULT, 4'd3, 0);
    idle("pipe_gap");

    step("div_ires", 0, 0, ZEROS, 0, 1, IRESULT, 4'd5,
         1, 1, IRESULT, 4'd5, 0);
    idle("div_gap");

    starve("starve1", A, 4'd9, 1);
    step("resume", 0, 1, RESULT, 4'd12, 0, ZEROS, 0,
         0, 1, RESULT, 4'd12, 0);

    for (int i = 1; i <= 5; i++)
      step("cont5", 0, 1, B, TW'(i), 1, IRESULT, 4'd7,
           0, 1, B, TW'(i), 0);
    step("div_drop", 0, 1, A, 4'd2, 0, ZEROS, 0,
         0, 1, A, 4'd2, 0);
    starve("restart", B, 4'd8, 1);

    exp_err = 1'b1;
    step("bad_sel", 0, 0, ZEROS, 0, 1, bad_sel, 4'd4,
         1, 1, ZEROS, 4'd4, 0);
    idle("err_hold");
    step("err_hold2", 0, 1, A, 4'd6, 0, ZEROS, 0,
         0, 1, A, 4'd6, 0);

    starve("pre_rst", IRESULT, 4'd11, 0);
    exp_err = 1'b0;
    step("rst_force", 1, 1, RESULT, 4'd1, 1, IRESULT, 4'd11,
         0, 0, ZEROS, 0, 0);
    starve("post_rst", A, 4'd13, 1);
    idle("tail");

    repeat (3) @(posedge clk);
    #3;
    n_vec++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d left want 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_fail);
    $finish;
  end

endmodule
